// File: rtl/osd_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : osd_text_sequencer
// Description : OSD text datapath sequencer. Walks text RAM -> font ROM ->
//               glyph shift register in step with the video dot counters,
//               prefetching the next cell's glyph row while the current cell
//               is shifted out, and drives pix_on_o / win_o to the RGB stage.
// Revision    : 1.0 - initial release
// ============================================================================
module osd_text_sequencer #(
  parameter int X0      = 40,
  parameter int Y0      = 20,
  parameter int CHAR_W  = 8,
  parameter int GLYPH_H = 12,
  parameter int PIX_REP = 2,
  parameter int COLS    = 16,
  parameter int ROWS    = 4,
  parameter int TXT_AW  = 6
) (
  input  logic              CLK_i,
  input  logic              NRST_i,
  input  logic              dot_en_i,
  input  logic [9:0]        h_cnt_i,
  input  logic [8:0]        v_cnt_i,
  input  logic              vblank_i,
  input  logic              osd_en_i,
  output logic [TXT_AW-1:0] txt_addr_o,
  input  logic [7:0]        txt_data_i,
  output logic [11:0]       font_addr_o,
  input  logic [7:0]        font_data_i,
  output logic              pix_on_o,
  output logic              win_o,
  output logic              fetch_late_o
);

  localparam int CELL_W = CHAR_W * PIX_REP;
  localparam int WIN_W  = COLS * CELL_W;
  localparam int WIN_H  = ROWS * GLYPH_H;
  localparam int GRW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CRW    = (ROWS > 1)    ? $clog2(ROWS)    : 1;
  localparam int CW     = (COLS > 1)    ? $clog2(COLS)    : 1;
  localparam int PW     = (CHAR_W > 1)  ? $clog2(CHAR_W)  : 1;
  localparam int RW     = (PIX_REP > 1) ? $clog2(PIX_REP) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TXT_WAIT  = 3'd1,
    S_FONT_ADDR = 3'd2,
    S_FONT_WAIT = 3'd3,
    S_LATCH     = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [GRW-1:0]    r_glyph_row, w_glyph_row_nxt;
  logic [CRW-1:0]    r_char_row, w_char_row_nxt;
  logic [CW-1:0]     r_col, w_col_nxt;
  logic [CHAR_W-1:0] r_next_glyph, r_shift;
  logic [PW-1:0]     r_pix, w_pix_nxt;
  logic [RW-1:0]     r_rep, w_rep_nxt;

  int   w_h_off, w_v_off, w_cell;
  logic w_vwin, w_hwin, w_trigger, w_load, w_start, w_win_nxt;

  // Window decode, line trigger / cell-load detect, row/column stepping and pixel counters
  always_comb begin
    w_h_off         = int'(h_cnt_i) - X0;
    w_v_off         = int'(v_cnt_i) - Y0;
    w_vwin          = (w_v_off >= 0) && (w_v_off < WIN_H);
    w_hwin          = (w_h_off >= 0) && (w_h_off < WIN_W);
    w_cell          = w_h_off / CELL_W;
    w_trigger       = dot_en_i && w_vwin && (w_h_off == -2);
    w_load          = dot_en_i && w_vwin && w_hwin && ((w_h_off % CELL_W) == 0);
    w_win_nxt       = w_vwin && w_hwin && osd_en_i;
    w_glyph_row_nxt = r_glyph_row;
    w_char_row_nxt  = r_char_row;
    w_col_nxt       = r_col;
    w_start         = 1'b0;
    if (w_trigger) begin
      w_start   = 1'b1;
      w_col_nxt = '0;
      if (w_v_off == 0) begin
        w_glyph_row_nxt = '0;
        w_char_row_nxt  = '0;
      end else if (int'(r_glyph_row) == GLYPH_H - 1) begin
        w_glyph_row_nxt = '0;
        w_char_row_nxt  = r_char_row + CRW'(1);
      end else begin
        w_glyph_row_nxt = r_glyph_row + GRW'(1);
      end
    end else if (w_load && (w_cell + 1 < COLS)) begin
      // Prefetch for the following cell starts on the load edge itself
      w_start   = 1'b1;
      w_col_nxt = CW'(w_cell + 1);
    end
    // Font pixel k of a cell spans PIX_REP dots; pixel index wraps at CHAR_W
    if (int'(r_rep) == PIX_REP - 1) begin
      w_rep_nxt = '0;
      w_pix_nxt = (int'(r_pix) == CHAR_W - 1) ? '0 : r_pix + PW'(1);
    end else begin
      w_rep_nxt = r_rep + RW'(1);
      w_pix_nxt = r_pix;
    end
  end

  // Fetch FSM next state: a new start always (re)launches, vblank parks it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = S_IDLE;
      S_TXT_WAIT:  w_state_nxt = S_FONT_ADDR;
      S_FONT_ADDR: w_state_nxt = S_FONT_WAIT;
      S_FONT_WAIT: w_state_nxt = S_LATCH;
      S_LATCH:     w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_start) w_state_nxt = S_TXT_WAIT;
    if (vblank_i) w_state_nxt = S_IDLE;
  end

  // Fetch FSM state register
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Text position counters, cleared during vertical blank
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      r_glyph_row <= '0;
      r_char_row  <= '0;
      r_col       <= '0;
    end else if (vblank_i) begin
      r_glyph_row <= '0;
      r_char_row  <= '0;
      r_col       <= '0;
    end else begin
      r_glyph_row <= w_glyph_row_nxt;
      r_char_row  <= w_char_row_nxt;
      r_col       <= w_col_nxt;
    end
  end

  // Memory addressing and glyph prefetch latch; addresses hold through vblank
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      txt_addr_o   <= '0;
      font_addr_o  <= '0;
      r_next_glyph <= '0;
    end else if (vblank_i) begin
      r_next_glyph <= '0;
    end else begin
      if (w_start)
        txt_addr_o <= TXT_AW'(int'(w_char_row_nxt) * COLS + int'(w_col_nxt));
      if (r_state == S_FONT_ADDR)
        font_addr_o <= 12'(int'(txt_data_i) * GLYPH_H + int'(r_glyph_row));
      if (r_state == S_LATCH)
        r_next_glyph <= font_data_i;
    end
  end

  // Per-dot pixel pipeline: cell load, shift position and registered outputs
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      r_shift  <= '0;
      r_pix    <= '0;
      r_rep    <= '0;
      pix_on_o <= 1'b0;
      win_o    <= 1'b0;
    end else if (vblank_i) begin
      r_shift  <= '0;
      r_pix    <= '0;
      r_rep    <= '0;
      pix_on_o <= 1'b0;
      win_o    <= 1'b0;
    end else if (dot_en_i) begin
      win_o <= w_win_nxt;
      if (w_load) begin
        r_shift  <= r_next_glyph;
        r_pix    <= '0;
        r_rep    <= '0;
        pix_on_o <= w_win_nxt && r_next_glyph[0];
      end else begin
        r_pix    <= w_pix_nxt;
        r_rep    <= w_rep_nxt;
        pix_on_o <= w_win_nxt && r_shift[w_pix_nxt];
      end
    end
  end

  // Sticky flag: a cell load arrived while the prefetch was still in flight
  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i)                          fetch_late_o <= 1'b0;
    else if (w_load && r_state != S_IDLE) fetch_late_o <= 1'b1;
  end

endmodule
`default_nettype wire
